// File: rtl/pwm_gesture_encoder.sv
// pwm_gesture_encoder
// Measures the high time of five servo PWM lines in microseconds, range-checks
// each pulse, tracks per-channel staleness, and folds the five widths into the
// 8-bit gesture code (8'h01 all high pose, 8'h02 all low pose, else 8'h00).
module pwm_gesture_encoder #(
   parameter int unsigned CLKS_PER_US      = 50,
   parameter int unsigned MIN_WIDTH_US     = 500,
   parameter int unsigned MAX_WIDTH_US     = 2500,
   parameter int unsigned FRAME_TIMEOUT_US = 25000,
   parameter int unsigned THRESH_HI_US     = 1550,
   parameter int unsigned THRESH_LO_US     = 1450
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  pwm_in,
   output logic [79:0] width_us,
   output logic [4:0]  ch_valid,
   output logic [4:0]  pulse_err,
   output logic [7:0]  gesture,
   output logic        gesture_strobe
);

   localparam int unsigned PS_W = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
   localparam int unsigned WC_W = $clog2(MAX_WIDTH_US + 2);
   localparam int unsigned TO_W = $clog2(FRAME_TIMEOUT_US + 1);

   localparam logic [PS_W-1:0] PS_LAST  = PS_W'(CLKS_PER_US - 1);
   localparam logic [WC_W-1:0] WC_MIN   = WC_W'(MIN_WIDTH_US);
   localparam logic [WC_W-1:0] WC_MAX   = WC_W'(MAX_WIDTH_US);
   localparam logic [WC_W-1:0] WC_OVER  = WC_W'(MAX_WIDTH_US + 1);
   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(FRAME_TIMEOUT_US);
   localparam logic [15:0]     TH_HI    = 16'(THRESH_HI_US);
   localparam logic [15:0]     TH_LO    = 16'(THRESH_LO_US);

   typedef enum logic [1:0] {
      S_ARM  = 2'd0,
      S_LOW  = 2'd1,
      S_HIGH = 2'd2
   } state_t;

   logic [4:0] r_sync1;
   logic [4:0] r_sync2;
   logic [4:0] r_prev;
   logic [4:0] w_rise;
   logic [4:0] w_fall;

   // Two-stage synchronizer plus edge register. Reset to all ones so a line
   // that is already high when reset releases never looks like a rising edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= '1;
         r_sync2 <= '1;
         r_prev  <= '1;
      end else begin
         r_sync1 <= pwm_in;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign w_rise = r_sync2 & ~r_prev;
   assign w_fall = ~r_sync2 & r_prev;

   for (genvar g = 0; g < 5; g++) begin : g_ch
      state_t          r_state;
      state_t          w_state_nxt;
      logic [PS_W-1:0] r_pre;
      logic [WC_W-1:0] r_wcnt;
      logic [PS_W-1:0] r_to_pre;
      logic [TO_W-1:0] r_to_cnt;
      logic [15:0]     r_width;
      logic            r_valid;
      logic            r_err;
      logic            w_start;
      logic            w_accept;
      logic            w_reject;

      // Channel FSM state register
      always_ff @(posedge clk or posedge reset) begin
         if (reset) r_state <= S_ARM;
         else       r_state <= w_state_nxt;
      end

      // Next state and pulse evaluation (accept / reject decisions)
      always_comb begin
         w_state_nxt = r_state;
         w_start     = 1'b0;
         w_accept    = 1'b0;
         w_reject    = 1'b0;
         case (r_state)
            S_ARM: begin
               if (!r_sync2[g]) w_state_nxt = S_LOW;
            end
            S_LOW: begin
               if (w_rise[g]) begin
                  w_state_nxt = S_HIGH;
                  w_start     = 1'b1;
               end
            end
            S_HIGH: begin
               if (w_fall[g]) begin
                  w_state_nxt = S_LOW;
                  if (r_wcnt >= WC_MIN && r_wcnt <= WC_MAX) w_accept = 1'b1;
                  else                                      w_reject = 1'b1;
               end else if (r_wcnt == WC_OVER) begin
                  w_state_nxt = S_ARM;
                  w_reject    = 1'b1;
               end
            end
            default: w_state_nxt = S_ARM;
         endcase
      end

      // Width prescaler and microsecond counter; the rising-edge cycle already
      // counts as the first high cycle so the result is floor(cycles/CLKS_PER_US).
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_pre  <= '0;
            r_wcnt <= '0;
         end else if (w_start) begin
            if (CLKS_PER_US == 1) begin
               r_pre  <= '0;
               r_wcnt <= WC_W'(1);
            end else begin
               r_pre  <= PS_W'(1);
               r_wcnt <= '0;
            end
         end else if (r_state == S_HIGH && r_wcnt != WC_OVER) begin
            if (r_pre == PS_LAST) begin
               r_pre  <= '0;
               r_wcnt <= r_wcnt + WC_W'(1);
            end else begin
               r_pre <= r_pre + PS_W'(1);
            end
         end
      end

      // Microseconds since the last rising edge, saturating at the timeout
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_to_pre <= '0;
            r_to_cnt <= '0;
         end else if (w_rise[g]) begin
            if (CLKS_PER_US == 1) begin
               r_to_pre <= '0;
               r_to_cnt <= TO_W'(1);
            end else begin
               r_to_pre <= PS_W'(1);
               r_to_cnt <= '0;
            end
         end else if (r_to_cnt != TO_LIMIT) begin
            if (r_to_pre == PS_LAST) begin
               r_to_pre <= '0;
               r_to_cnt <= r_to_cnt + TO_W'(1);
            end else begin
               r_to_pre <= r_to_pre + PS_W'(1);
            end
         end
      end

      // Channel outputs: latch accepted width, flag errors, expire stale data
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_width <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
         end else begin
            r_err <= w_reject;
            if (w_accept) begin
               r_width <= 16'(r_wcnt);
               r_valid <= 1'b1;
            end else if (w_reject) begin
               r_valid <= 1'b0;
            end
            if (r_to_cnt == TO_LIMIT) r_valid <= 1'b0;
         end
      end

      assign width_us[16*g +: 16] = r_width;
      assign ch_valid[g]          = r_valid;
      assign pulse_err[g]         = r_err;
   end

   logic       w_all_hi;
   logic       w_all_lo;
   logic [7:0] w_gest_nxt;
   logic [7:0] r_gesture;
   logic       r_strobe;

   // Pose classification over all five channels
   always_comb begin
      w_all_hi = 1'b1;
      w_all_lo = 1'b1;
      for (int unsigned i = 0; i < 5; i++) begin
         if (width_us[16*i +: 16] < TH_HI) w_all_hi = 1'b0;
         if (width_us[16*i +: 16] > TH_LO) w_all_lo = 1'b0;
      end
      w_gest_nxt = 8'h00;
      if (&ch_valid) begin
         if (w_all_hi)      w_gest_nxt = 8'h01;
         else if (w_all_lo) w_gest_nxt = 8'h02;
      end
   end

   // Gesture register with change strobe
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_gesture <= 8'h00;
         r_strobe  <= 1'b0;
      end else begin
         r_gesture <= w_gest_nxt;
         r_strobe  <= (w_gest_nxt != r_gesture);
      end
   end

   assign gesture        = r_gesture;
   assign gesture_strobe = r_strobe;

endmodule

// File: tb/tb_pwm_gesture_encoder.sv
// Testbench for pwm_gesture_encoder with time-scaled parameters.
// A frame-level reference model tracks expected widths, validity and gesture
// changes from the commanded pulse widths.
module tb_pwm_gesture_encoder;

   localparam int C    = 2;
   localparam int MINW = 50;
   localparam int MAXW = 250;
   localparam int TOUT = 2500;
   localparam int THI  = 155;
   localparam int TLO  = 145;
   localparam int L    = 1000 * C;   // frame length in clk cycles

   logic        clk;
   logic        reset;
   logic [4:0]  pwm_in;
   logic [79:0] width_us;
   logic [4:0]  ch_valid;
   logic [4:0]  pulse_err;
   logic [7:0]  gesture;
   logic        gesture_strobe;

   int n_checks = 0;
   int n_errors = 0;

   int          fw [5];
   int          mw [5];
   bit          mv [5];
   logic [7:0]  mg;

   pwm_gesture_encoder #(
      .CLKS_PER_US(C),
      .MIN_WIDTH_US(MINW),
      .MAX_WIDTH_US(MAXW),
      .FRAME_TIMEOUT_US(TOUT),
      .THRESH_HI_US(THI),
      .THRESH_LO_US(TLO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .pwm_in(pwm_in),
      .width_us(width_us),
      .ch_valid(ch_valid),
      .pulse_err(pulse_err),
      .gesture(gesture),
      .gesture_strobe(gesture_strobe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int got, input int exp, input int tol);
      int diff;
      n_checks++;
      diff = (got > exp) ? got - exp : exp - got;
      if (diff > tol) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
      end
   endtask

   function automatic logic [7:0] model_gesture();
      bit all_v = 1'b1;
      bit all_h = 1'b1;
      bit all_l = 1'b1;
      for (int n = 0; n < 5; n++) begin
         if (!mv[n]) all_v = 1'b0;
         if (mw[n] < THI) all_h = 1'b0;
         if (mw[n] > TLO) all_l = 1'b0;
      end
      if (all_v && all_h) return 8'h01;
      if (all_v && all_l) return 8'h02;
      return 8'h00;
   endfunction

   task automatic check_outputs(input string name);
      for (int n = 0; n < 5; n++) begin
         check_eq($sformatf("%s_width%0d", name, n), int'(width_us[16*n +: 16]), mw[n], 0);
         check_eq($sformatf("%s_valid%0d", name, n), int'(ch_valid[n]), int'(mv[n]), 0);
      end
      check_eq($sformatf("%s_gesture", name), int'(gesture), int'(mg), 0);
   endtask

   // One frame: every line rises at frame start and stays high fw[n] us.
   task automatic run_frame(input string name);
      int         t_ev [5];
      bit         done [5];
      int         errs [5];
      int         err_at [5];
      int         exp_strobes;
      int         strobes;
      int         bad_align;
      logic [7:0] g_cur;
      logic [7:0] g_new;
      logic [7:0] prev_g;
      int         tmin;

      // Reference: apply channel outcomes in time order, count gesture changes
      for (int n = 0; n < 5; n++) begin
         t_ev[n] = (fw[n] > MAXW) ? (MAXW + 1) * C : fw[n] * C;
         done[n] = 1'b0;
      end
      exp_strobes = 0;
      g_cur = mg;
      for (int k = 0; k < 5; k++) begin
         tmin = -1;
         for (int n = 0; n < 5; n++)
            if (!done[n] && (tmin < 0 || t_ev[n] < tmin)) tmin = t_ev[n];
         if (tmin >= 0) begin
            for (int n = 0; n < 5; n++) begin
               if (!done[n] && t_ev[n] == tmin) begin
                  done[n] = 1'b1;
                  if (fw[n] >= MINW && fw[n] <= MAXW) begin
                     mw[n] = fw[n];
                     mv[n] = 1'b1;
                  end else begin
                     mv[n] = 1'b0;
                  end
               end
            end
            g_new = model_gesture();
            if (g_new != g_cur) exp_strobes++;
            g_cur = g_new;
         end
      end
      mg = g_cur;

      strobes   = 0;
      bad_align = 0;
      prev_g    = gesture;
      for (int n = 0; n < 5; n++) begin
         errs[n]   = 0;
         err_at[n] = -1;
      end
      for (int t = 0; t < L; t++) begin
         for (int n = 0; n < 5; n++) pwm_in[n] = (t < fw[n] * C);
         @(posedge clk);
         #1;
         if (gesture_strobe) strobes++;
         if (gesture_strobe != (gesture != prev_g)) bad_align++;
         prev_g = gesture;
         for (int n = 0; n < 5; n++) begin
            if (pulse_err[n]) begin
               errs[n]++;
               if (err_at[n] < 0) err_at[n] = t;
            end
         end
      end

      check_outputs(name);
      check_eq($sformatf("%s_strobes", name), strobes, exp_strobes, 0);
      check_eq($sformatf("%s_strobe_align", name), bad_align, 0, 0);
      for (int n = 0; n < 5; n++) begin
         check_eq($sformatf("%s_err%0d", name, n), errs[n],
                  (fw[n] < MINW || fw[n] > MAXW) ? 1 : 0, 0);
         if (fw[n] > MAXW) begin
            // error reported (MAXW+1) us after the rise plus 3 cycles edge latency
            check_eq($sformatf("%s_ovl_time%0d", name, n), err_at[n] + 1,
                     (MAXW + 1) * C + 3, 3);
            check_eq($sformatf("%s_ovl_while_high%0d", name, n),
                     int'(err_at[n] + 1 < fw[n] * C), 1, 0);
         end
      end
   endtask

   task automatic set_all(input int w);
      for (int n = 0; n < 5; n++) fw[n] = w;
   endtask

   initial begin
      int         fall_edge;
      int         strobes;
      int         errs;
      int         mode;
      logic [7:0] g_before;

      reset  = 1'b1;
      pwm_in = '0;
      for (int n = 0; n < 5; n++) begin
         mw[n] = 0;
         mv[n] = 1'b0;
      end
      mg = 8'h00;
      repeat (4) @(posedge clk);
      #1;
      check_outputs("reset");
      check_eq("reset_err", int'(pulse_err), 0, 0);
      check_eq("reset_strobe", int'(gesture_strobe), 0, 0);
      reset = 1'b0;
      repeat (20) @(posedge clk);
      #1;

      // Directed frames
      set_all(160); run_frame("hi1");
      set_all(160); run_frame("hi2");
      set_all(140); run_frame("lo1");
      set_all(140); run_frame("lo2");
      set_all(160); fw[0] = 155; run_frame("thumb_thresh");
      set_all(160); fw[0] = 150; run_frame("thumb_mid");
      set_all(MINW); run_frame("min_edge");
      set_all(MAXW); run_frame("max_edge");
      set_all(160); fw[2] = 30; run_frame("short_ch2");
      set_all(160); fw[0] = 300; run_frame("overlong");
      set_all(160); run_frame("after_ovl");

      // Randomized frames
      for (int f = 0; f < 10; f++) begin
         mode = $urandom_range(0, 2);
         for (int n = 0; n < 5; n++) begin
            case (mode)
               0:       fw[n] = $urandom_range(THI, MAXW);
               1:       fw[n] = $urandom_range(MINW, TLO);
               default: fw[n] = $urandom_range(30, 300);
            endcase
         end
         run_frame($sformatf("rnd%0d", f));
      end

      // Pinky held low after a valid frame: it must go stale
      set_all(160); run_frame("pre_timeout");
      g_before  = mg;
      mv[4]     = 1'b0;
      mg        = model_gesture();
      fall_edge = -1;
      strobes   = 0;
      for (int t = 0; t < 3 * L; t++) begin
         for (int n = 0; n < 4; n++) pwm_in[n] = ((t % L) < 160 * C);
         pwm_in[4] = 1'b0;
         @(posedge clk);
         #1;
         if (gesture_strobe) strobes++;
         if (fall_edge < 0 && !ch_valid[4]) fall_edge = L + t + 1;
      end
      check_eq("timeout_time", fall_edge, TOUT * C + 3, 3);
      check_eq("timeout_strobes", strobes, (mg != g_before) ? 1 : 0, 0);
      check_outputs("timeout");

      // Reset in the middle of a pulse, lines held high through release
      pwm_in = '1;
      repeat (100) @(posedge clk);
      #1;
      reset = 1'b1;
      for (int n = 0; n < 5; n++) begin
         mw[n] = 0;
         mv[n] = 1'b0;
      end
      mg = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check_outputs("in_reset");
      reset   = 1'b0;
      errs    = 0;
      strobes = 0;
      for (int t = 0; t < 1800; t++) begin
         pwm_in = (t < 300) ? 5'b11111 : 5'b00000;
         @(posedge clk);
         #1;
         if (pulse_err != 5'b00000) errs++;
         if (gesture_strobe) strobes++;
      end
      check_eq("post_reset_err", errs, 0, 0);
      check_eq("post_reset_strobes", strobes, 0, 0);
      check_outputs("post_reset");
      set_all(160); run_frame("fresh");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
